// File: rtl/store_unit.sv
// store_unit: write side of the data memory path.
// Takes SB/SH/SW store requests from the execute stage and issues
// word-aligned, byte-enabled write beats on the data memory bus.
// A store that crosses a word boundary is issued as two beats. Each
// accepted request ends with exactly one st_done or one st_err pulse.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   st_valid/st_ready   request handshake; ready only while idle
//   st_funct3           000=SB, 001=SH, 010=SW, anything else is illegal
//   st_addr, st_data    byte address and store data (low bytes used)
//   mem_req/mem_gnt     write beat handshake; mem_we mirrors mem_req
//   mem_addr            word-aligned beat address
//   mem_wdata, mem_be   lane-positioned write data and byte enables
//   st_done, st_err     one-cycle completion / error pulses
module store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_done,
  output logic        st_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Second-beat information captured at accept time. The first beat is
  // presented straight from the request, so only the upper half is kept.
  logic [29:0] base_r;
  logic [3:0]  be_hi_r;
  logic [31:0] wd_hi_r;

  logic [3:0]  mask_s;
  logic [31:0] mdata_s;
  logic        legal_s;
  logic        misaligned_s;
  logic        reject_s;
  logic [1:0]  off_s;
  logic [7:0]  be8_s;
  logic [63:0] d64_s;
  logic        latch_s;

  logic        req_next_s;
  logic [31:0] addr_next_s;
  logic [31:0] wdata_next_s;
  logic [3:0]  be_next_s;
  logic        done_next_s;
  logic        err_next_s;
  logic        ready_next_s;

  assign off_s = st_addr[1:0];

  // Size decode: byte mask, zero-extended store data and legality.
  always_comb begin
    mask_s       = 4'b0000;
    mdata_s      = 32'd0;
    legal_s      = 1'b0;
    misaligned_s = 1'b0;
    case (st_funct3)
      3'b000: begin
        mask_s  = 4'b0001;
        mdata_s = {24'd0, st_data[7:0]};
        legal_s = 1'b1;
      end
      3'b001: begin
        mask_s       = 4'b0011;
        mdata_s      = {16'd0, st_data[15:0]};
        legal_s      = 1'b1;
        misaligned_s = st_addr[0];
      end
      3'b010: begin
        mask_s       = 4'b1111;
        mdata_s      = st_data;
        legal_s      = 1'b1;
        misaligned_s = (off_s != 2'b00);
      end
      default: begin
        mask_s       = 4'b0000;
        mdata_s      = 32'd0;
        legal_s      = 1'b0;
        misaligned_s = 1'b0;
      end
    endcase
  end

  // Shifting across an 8-lane / 64-bit window places any bytes that
  // spill past the word boundary into the upper half, i.e. the second beat.
  assign be8_s    = {4'b0000, mask_s} << off_s;
  assign d64_s    = {32'd0, mdata_s} << {off_s, 3'b000};
  assign reject_s = !legal_s || ((ALLOW_MISALIGNED == 1'b0) && misaligned_s);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-output decode; outputs are registered below so the
  // bus sees glitch-free values that stay put until the grant.
  always_comb begin
    state_next_s = state_r;
    req_next_s   = 1'b0;
    addr_next_s  = 32'd0;
    wdata_next_s = 32'd0;
    be_next_s    = 4'b0000;
    done_next_s  = 1'b0;
    err_next_s   = 1'b0;
    ready_next_s = 1'b0;
    latch_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (st_valid) begin
          latch_s = 1'b1;
          if (reject_s) begin
            state_next_s = ERR;
            err_next_s   = 1'b1;
          end else begin
            state_next_s = BEAT0;
            req_next_s   = 1'b1;
            addr_next_s  = {st_addr[31:2], 2'b00};
            wdata_next_s = d64_s[31:0];
            be_next_s    = be8_s[3:0];
          end
        end else begin
          ready_next_s = 1'b1;
        end
      end
      BEAT0: begin
        if (mem_gnt) begin
          if (be_hi_r != 4'b0000) begin
            state_next_s = BEAT1;
            req_next_s   = 1'b1;
            addr_next_s  = {base_r + 30'd1, 2'b00};
            wdata_next_s = wd_hi_r;
            be_next_s    = be_hi_r;
          end else begin
            state_next_s = RESP;
            done_next_s  = 1'b1;
          end
        end else begin
          req_next_s   = 1'b1;
          addr_next_s  = mem_addr;
          wdata_next_s = mem_wdata;
          be_next_s    = mem_be;
        end
      end
      BEAT1: begin
        if (mem_gnt) begin
          state_next_s = RESP;
          done_next_s  = 1'b1;
        end else begin
          req_next_s   = 1'b1;
          addr_next_s  = mem_addr;
          wdata_next_s = mem_wdata;
          be_next_s    = mem_be;
        end
      end
      RESP: begin
        state_next_s = IDLE;
        ready_next_s = 1'b1;
      end
      ERR: begin
        state_next_s = IDLE;
        ready_next_s = 1'b1;
      end
      default: begin
        state_next_s = IDLE;
        ready_next_s = 1'b1;
      end
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_ready  <= ready_next_s;
      mem_req   <= req_next_s;
      mem_addr  <= addr_next_s;
      mem_wdata <= wdata_next_s;
      mem_be    <= be_next_s;
      st_done   <= done_next_s;
      st_err    <= err_next_s;
    end
  end

  // Second-beat capture at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r  <= 30'd0;
      be_hi_r <= 4'b0000;
      wd_hi_r <= 32'd0;
    end else if (latch_s) begin
      base_r  <= st_addr[31:2];
      be_hi_r <= be8_s[7:4];
      wd_hi_r <= d64_s[63:32];
    end else begin
      base_r  <= base_r;
      be_hi_r <= be_hi_r;
      wd_hi_r <= wd_hi_r;
    end
  end

  assign mem_we = mem_req;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_gnt;

  // dut1: ALLOW_MISALIGNED=1, dut0: ALLOW_MISALIGNED=0; shared inputs.
  logic        ready1, req1, we1, done1, err1;
  logic [31:0] addr1, wdata1;
  logic [3:0]  be1;
  logic        ready0, req0, we0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;

  int checks   = 0;
  int failures = 0;

  // Reference expectations for the current request.
  logic [31:0] exp_addr [2];
  logic [31:0] exp_wd   [2];
  logic [3:0]  exp_be   [2];
  int          exp_nb;
  bit          exp_err;

  always #5 clk = ~clk;

  store_unit #(.ALLOW_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(ready1),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(req1), .mem_gnt(mem_gnt), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_be(be1), .st_done(done1), .st_err(err1)
  );

  store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(ready0),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(req0), .mem_gnt(mem_gnt), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_be(be0), .st_done(done0), .st_err(err0)
  );

  // Byte-by-byte model: each stored byte goes to the word containing its
  // own address; a second word means a second beat.
  task automatic model(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit allow);
    int size;
    logic [31:0] w0, ba, w;
    int idx;
    bit mis;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    mis  = (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    exp_err = (f3 > 3'd2) || (!allow && mis);
    w0 = a & 32'hFFFF_FFFC;
    exp_nb = 1;
    for (int i = 0; i < 2; i++) begin
      exp_addr[i] = 32'd0;
      exp_wd[i]   = 32'd0;
      exp_be[i]   = 4'd0;
    end
    for (int k = 0; k < size; k++) begin
      ba  = a + 32'(k);
      w   = ba & 32'hFFFF_FFFC;
      idx = (w == w0) ? 0 : 1;
      if (idx == 1) exp_nb = 2;
      exp_addr[idx] = w;
      exp_be[idx][ba[1:0]] = 1'b1;
      exp_wd[idx][ba[1:0]*8 +: 8] = d[k*8 +: 8];
    end
  endtask

  // Drives one request and checks every cycle until the unit is idle again.
  // stall = number of cycles mem_gnt stays low at the start of each beat.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int stall, input bit use0);
    int last, busy_end, beat;
    bit in_beat;
    logic o_req, o_we, o_done, o_err, o_ready;
    logic [31:0] o_addr, o_wd;
    logic [3:0] o_be;
    model(f3, a, d, !use0);
    @(negedge clk);
    checks++;
    if ((use0 ? ready0 : ready1) !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_accept got=%b exp=1", use0 ? ready0 : ready1);
    end
    st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d; mem_gnt = 1'b0;
    @(negedge clk);
    st_valid = 1'b0; st_funct3 = 3'($urandom); st_addr = $urandom; st_data = $urandom;
    busy_end = exp_err ? 1 : exp_nb * (stall + 1) + 1;
    last     = exp_err ? 4 : busy_end + 1;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      o_req   = use0 ? req0   : req1;
      o_we    = use0 ? we0    : we1;
      o_done  = use0 ? done0  : done1;
      o_err   = use0 ? err0   : err1;
      o_ready = use0 ? ready0 : ready1;
      o_addr  = use0 ? addr0  : addr1;
      o_wd    = use0 ? wdata0 : wdata1;
      o_be    = use0 ? be0    : be1;
      in_beat = !exp_err && (c <= exp_nb * (stall + 1));
      beat    = (c - 1) / (stall + 1);
      if (beat > 1) beat = 1;
      checks++;
      if (o_req !== in_beat || o_we !== o_req) begin
        failures++;
        $display("FAIL req c=%0d got req=%b we=%b exp=%b", c, o_req, o_we, in_beat);
      end
      if (in_beat) begin
        checks++;
        if (o_addr !== exp_addr[beat] || o_be !== exp_be[beat] || o_wd !== exp_wd[beat]) begin
          failures++;
          $display("FAIL beat%0d c=%0d got addr=%h be=%b wd=%h exp addr=%h be=%b wd=%h",
                   beat, c, o_addr, o_be, o_wd, exp_addr[beat], exp_be[beat], exp_wd[beat]);
        end
      end else begin
        checks++;
        if (o_be !== 4'b0000) begin
          failures++;
          $display("FAIL be_idle c=%0d got=%b exp=0000", c, o_be);
        end
      end
      checks++;
      if (o_done !== (!exp_err && c == busy_end) || o_err !== (exp_err && c == 1)) begin
        failures++;
        $display("FAIL resp c=%0d got done=%b err=%b exp done=%b err=%b", c, o_done, o_err,
                 (!exp_err && c == busy_end), (exp_err && c == 1));
      end
      checks++;
      if (o_ready !== (c > busy_end)) begin
        failures++;
        $display("FAIL ready c=%0d got=%b exp=%b", c, o_ready, (c > busy_end));
      end
      mem_gnt = exp_err ? 1'b1 : (in_beat && ((c - 1) % (stall + 1) == stall));
      // A request offered while busy must be ignored.
      if (stall >= 3 && c == 2) begin
        st_valid = 1'b1; st_funct3 = 3'd0; st_addr = 32'h0000_0100; st_data = $urandom;
      end
      if (c == 3) st_valid = 1'b0;
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || req1 !== 1'b0 || we1 !== 1'b0 || addr1 !== 32'd0 ||
        wdata1 !== 32'd0 || be1 !== 4'd0 || done1 !== 1'b0 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1 got ready=%b req=%b addr=%h wd=%h be=%b done=%b err=%b exp 1 0 0 0 0 0 0",
               ready1, req1, addr1, wdata1, be1, done1, err1);
    end
    checks++;
    if (ready0 !== 1'b1 || req0 !== 1'b0 || we0 !== 1'b0 || addr0 !== 32'd0 ||
        wdata0 !== 32'd0 || be0 !== 4'd0 || done0 !== 1'b0 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0 got ready=%b req=%b addr=%h wd=%h be=%b done=%b err=%b exp 1 0 0 0 0 0 0",
               ready0, req0, addr0, wdata0, be0, done0, err0);
    end
    rst = 1'b0;
  endtask

  task automatic test_aligned();
    run_store(3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0);
    run_store(3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b1);
  endtask

  task automatic test_lanes();
    run_store(3'd0, 32'h0000_1003, 32'hFFFF_FFA5, 0, 1'b0);
    run_store(3'd1, 32'h0000_1001, 32'hFFFF_1234, 0, 1'b0);
    run_store(3'd1, 32'h0000_1002, 32'hABCD_5678, 1, 1'b1);
  endtask

  task automatic test_split();
    run_store(3'd1, 32'h0000_2003, 32'h0000_1234, 0, 1'b0);
    run_store(3'd2, 32'hFFFF_FFFE, 32'h1122_3344, 0, 1'b0);
    run_store(3'd2, 32'h0000_3001, 32'hCAFE_F00D, 2, 1'b0);
  endtask

  task automatic test_err();
    run_store(3'd2, 32'h0000_2002, 32'h1234_5678, 0, 1'b1);
    run_store(3'd1, 32'h0000_2001, 32'h1234_5678, 0, 1'b1);
    run_store(3'd3, 32'h0000_2000, 32'h1234_5678, 0, 1'b0);
    run_store(3'd3, 32'h0000_2000, 32'h1234_5678, 0, 1'b1);
    run_store(3'd7, 32'h0000_2004, 32'h1234_5678, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_store(3'd2, 32'h0000_4000, 32'h0BAD_F00D, 5, 1'b0);
    run_store(3'd0, 32'h0000_0100, 32'h0000_0077, 0, 1'b0);
  endtask

  task automatic test_rst_mid();
    bit seen_done;
    model(3'd1, 32'h0000_2003, 32'h0000_1234, 1'b1);
    @(negedge clk);
    st_valid = 1'b1; st_funct3 = 3'd1; st_addr = 32'h0000_2003; st_data = 32'h0000_1234;
    @(negedge clk);
    st_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++;
    if (req1 !== 1'b1 || addr1 !== exp_addr[1] || be1 !== exp_be[1]) begin
      failures++;
      $display("FAIL rst_mid_beat1 got req=%b addr=%h be=%b exp req=1 addr=%h be=%b",
               req1, addr1, be1, exp_addr[1], exp_be[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req1 !== 1'b0 || ready1 !== 1'b1 || be1 !== 4'd0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_after got req=%b ready=%b be=%b done=%b exp 0 1 0000 0",
               req1, ready1, be1, done1);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done1 === 1'b1 || req1 === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL rst_mid_abandon got activity=1 exp=0");
    end
    run_store(3'd0, 32'h0000_5002, 32'h0000_00C3, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int n = 0; n < 40; n++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      run_store(f3, $urandom, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  // Both outputs pulsing together is never legal.
  always @(negedge clk) begin
    if (!rst && ((done1 && err1) || (done0 && err0))) begin
      checks++;
      failures++;
      $display("FAIL done_err_overlap got dut1=%b%b dut0=%b%b exp no overlap",
               done1, err1, done0, err0);
    end
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_funct3 = 3'd0; st_addr = 32'd0; st_data = 32'd0;
    mem_gnt = 1'b0;
    test_reset();
    test_aligned();
    test_lanes();
    test_split();
    test_err();
    test_stall();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
